// File: rtl/perceptron_layer_sched.sv
// -----------------------------------------------------------------------------
// perceptron_layer_sched
//
// Time-multiplexes one shared Perceptron instance across a layer of M neurons.
// One input vector is accepted per handshake. M weight/bias rows are then
// streamed from an external synchronous weight memory through the perceptron,
// and the M results are collected into an output vector that is held on a
// valid/ready port until the consumer takes it.
//
// Optional feature macro: PERC_SCHED_RELU_EN
//   defined     : each captured result passes through ReLU (negatives store as 0)
//   not defined : p_y is stored unmodified (default)
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  input vector handshake (in_ready high only in idle)
//   in_x               input vector, N elements of DATA_WIDTH, sampled on accept
//   w_rd_en, w_addr    weight memory read strobe and row index
//   w_data, b_data     weight row and bias, valid one cycle after w_rd_en
//   p_x, p_w, p_b      drive the perceptron x/w/b inputs
//   p_y                perceptron result
//   out_valid/out_ready result vector handshake
//   out_y              M results, element k = neuron k (two's complement)
//   busy               high in any state except idle
// -----------------------------------------------------------------------------
module perceptron_layer_sched #(
   parameter int unsigned N          = 4,
   parameter int unsigned M          = 8,
   parameter int unsigned PERC_LAT   = 1,
   parameter int unsigned DATA_WIDTH = 8,
   localparam int unsigned AW        = (M > 1) ? $clog2(M) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   // input vector port
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [N-1:0][DATA_WIDTH-1:0]     in_x,
   // weight memory port
   output logic                             w_rd_en,
   output logic [AW-1:0]                    w_addr,
   input  logic [N-1:0][DATA_WIDTH-1:0]     w_data,
   input  logic [DATA_WIDTH-1:0]            b_data,
   // perceptron port
   output logic [N-1:0][DATA_WIDTH-1:0]     p_x,
   output logic [N-1:0][DATA_WIDTH-1:0]     p_w,
   output logic [DATA_WIDTH-1:0]            p_b,
   input  logic [DATA_WIDTH-1:0]            p_y,
   // result port
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [M-1:0][DATA_WIDTH-1:0]     out_y,
   output logic                             busy
);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StDone
   } state_t;

   localparam logic [AW-1:0] LastRow = AW'(M - 1);

   state_t                           state;
   logic [N-1:0][DATA_WIDTH-1:0]     x_reg;

   // Tag pipeline. The registered w_rd_en/w_addr pair is the issue stage; the
   // PERC_LAT stages below follow it, so the last stage lines up with the cycle
   // in which p_y for that row is valid.
   logic [PERC_LAT-1:0]              tag_vld;
   logic [PERC_LAT-1:0][AW-1:0]      tag_idx;

   logic                             cap_vld;
   logic [AW-1:0]                    cap_idx;
   logic [DATA_WIDTH-1:0]            cap_val;
   logic                             pipe_empty;

   // ---------------------------------------------------------------------------
   // Perceptron operand routing
   // ---------------------------------------------------------------------------
   assign p_x = x_reg;
   assign p_w = w_data;
   assign p_b = b_data;

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         w_rd_en   <= 1'b0;
         w_addr    <= '0;
         x_reg     <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid) begin
                  x_reg    <= in_x;
                  w_addr   <= '0;
                  w_rd_en  <= 1'b1;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= StIssue;
               end
            end
            StIssue: begin
               // one row per cycle, no stalls
               if (w_addr == LastRow) begin
                  w_rd_en <= 1'b0;
                  w_addr  <= '0;
                  state   <= StDrain;
               end else begin
                  w_addr <= w_addr + AW'(1);
               end
            end
            StDrain: begin
               // the last row's tag is still in flight on the first drain cycle,
               // so emptiness here means result M-1 has already been written
               if (pipe_empty) begin
                  out_valid <= 1'b1;
                  state     <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Tag pipeline
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld <= '0;
         tag_idx <= '0;
      end else begin
         tag_vld[0] <= w_rd_en;
         tag_idx[0] <= w_addr;
         for (int i = 1; i < int'(PERC_LAT); i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_idx[i] <= tag_idx[i-1];
         end
      end
   end

   assign pipe_empty = ~|tag_vld;
   assign cap_vld    = tag_vld[PERC_LAT-1];
   assign cap_idx    = tag_idx[PERC_LAT-1];

   // ---------------------------------------------------------------------------
   // Result post-processing
   // ---------------------------------------------------------------------------
   always_comb begin
      cap_val = p_y;
`ifdef PERC_SCHED_RELU_EN
      if (p_y[DATA_WIDTH-1]) begin
         cap_val = '0;
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // Result vector: entries persist until overwritten by the next layer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_y <= '0;
      end else begin
         for (int k = 0; k < int'(M); k++) begin
            if (cap_vld && (cap_idx == AW'(k))) begin
               out_y[k] <= cap_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_perceptron_layer_sched.sv
// -----------------------------------------------------------------------------
// tb_perceptron_layer_sched
//
// Self-checking bench for perceptron_layer_sched. Two instances: the default
// configuration (N=4, M=8, PERC_LAT=1) and a sweep point (M=1, PERC_LAT=3).
// Each has a synchronous weight memory model and an ideal perceptron model
// (y = x.w + b truncated to DATA_WIDTH, latency PERC_LAT). Expected layer
// results come from a per-neuron dot-product reference.
// -----------------------------------------------------------------------------
module tb_perceptron_layer_sched;

   localparam int N  = 4;
   localparam int M  = 8;
   localparam int L  = 1;
   localparam int DW = 8;
   localparam int LB = 3;

   typedef logic signed [DW-1:0] elem_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

`ifdef PERC_SCHED_RELU_EN
   localparam bit Relu = 1'b1;
`else
   localparam bit Relu = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // DUT A: defaults
   // ---------------------------------------------------------------------------
   logic                    in_valid_a  = 1'b0;
   logic                    in_ready_a;
   logic [N-1:0][DW-1:0]    in_x_a      = '0;
   logic                    w_rd_en_a;
   logic [2:0]              w_addr_a;
   logic [N-1:0][DW-1:0]    w_data_a;
   logic [DW-1:0]           b_data_a;
   logic [N-1:0][DW-1:0]    p_x_a, p_w_a;
   logic [DW-1:0]           p_b_a, p_y_a;
   logic                    out_valid_a;
   logic                    out_ready_a = 1'b0;
   logic [M-1:0][DW-1:0]    out_y_a;
   logic                    busy_a;

   perceptron_layer_sched #(.N(N), .M(M), .PERC_LAT(L), .DATA_WIDTH(DW)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_x(in_x_a),
      .w_rd_en(w_rd_en_a), .w_addr(w_addr_a), .w_data(w_data_a), .b_data(b_data_a),
      .p_x(p_x_a), .p_w(p_w_a), .p_b(p_b_a), .p_y(p_y_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_y(out_y_a),
      .busy(busy_a)
   );

   elem_t wmem_a [M][N];
   elem_t bmem_a [M];
   elem_t xa [N];

   always @(posedge clk) begin
      if (w_rd_en_a) begin
         for (int i = 0; i < N; i++) w_data_a[i] <= wmem_a[w_addr_a][i];
         b_data_a <= bmem_a[w_addr_a];
      end
   end

   function automatic logic [DW-1:0] dot(input logic [N-1:0][DW-1:0] x,
                                         input logic [N-1:0][DW-1:0] w,
                                         input logic [DW-1:0] b);
      int acc;
      acc = int'($signed(b));
      for (int i = 0; i < N; i++) acc += int'($signed(x[i])) * int'($signed(w[i]));
      return acc[DW-1:0];
   endfunction

   // PERC_LAT = 1: result valid in the same cycle as the operands
   assign p_y_a = dot(p_x_a, p_w_a, p_b_a);

   // ---------------------------------------------------------------------------
   // DUT B: M=1, PERC_LAT=3
   // ---------------------------------------------------------------------------
   logic                    in_valid_b  = 1'b0;
   logic                    in_ready_b;
   logic [N-1:0][DW-1:0]    in_x_b      = '0;
   logic                    w_rd_en_b;
   logic [0:0]              w_addr_b;
   logic [N-1:0][DW-1:0]    w_data_b;
   logic [DW-1:0]           b_data_b;
   logic [N-1:0][DW-1:0]    p_x_b, p_w_b;
   logic [DW-1:0]           p_b_b, p_y_b, y0_b, y1_b, y2_b;
   logic                    out_valid_b;
   logic                    out_ready_b = 1'b0;
   logic [0:0][DW-1:0]      out_y_b;
   logic                    busy_b;

   perceptron_layer_sched #(.N(N), .M(1), .PERC_LAT(LB), .DATA_WIDTH(DW)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_x(in_x_b),
      .w_rd_en(w_rd_en_b), .w_addr(w_addr_b), .w_data(w_data_b), .b_data(b_data_b),
      .p_x(p_x_b), .p_w(p_w_b), .p_b(p_b_b), .p_y(p_y_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_y(out_y_b),
      .busy(busy_b)
   );

   elem_t wmem_b [N];
   elem_t bmem_b;
   elem_t xb [N];

   always @(posedge clk) begin
      if (w_rd_en_b) begin
         for (int i = 0; i < N; i++) w_data_b[i] <= wmem_b[i];
         b_data_b <= bmem_b;
      end
   end

   // PERC_LAT = 3: two register stages behind the combinational product
   assign y0_b = dot(p_x_b, p_w_b, p_b_b);
   always @(posedge clk) begin
      y1_b <= y0_b;
      y2_b <= y1_b;
   end
   assign p_y_b = y2_b;

   // ---------------------------------------------------------------------------
   // Reference model and helpers
   // ---------------------------------------------------------------------------
   function automatic elem_t neuron(input elem_t xs[N], input elem_t ws[N], input elem_t b);
      int    acc;
      elem_t t;
      acc = int'(b);
      for (int i = 0; i < N; i++) acc += int'(xs[i]) * int'(ws[i]);
      t = elem_t'(acc);
      if (Relu && t < 0) t = '0;
      return t;
   endfunction

   function automatic logic [M*DW-1:0] ref_a(input elem_t xs[N]);
      logic [M*DW-1:0] r;
      elem_t           row [N];
      for (int k = 0; k < M; k++) begin
         for (int i = 0; i < N; i++) row[i] = wmem_a[k][i];
         r[k*DW +: DW] = neuron(xs, row, bmem_a[k]);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rand_mem_a();
      for (int k = 0; k < M; k++) begin
         for (int i = 0; i < N; i++) wmem_a[k][i] = elem_t'($urandom);
         bmem_a[k] = elem_t'($urandom);
      end
      for (int i = 0; i < N; i++) xa[i] = elem_t'($urandom);
   endtask

   // Runs one layer on DUT A from idle; leaves it in the done state.
   task automatic run_layer_a(input string tag, input logic [M*DW-1:0] exp);
      int n;
      int nrd;
      @(negedge clk);
      for (int i = 0; i < N; i++) in_x_a[i] = xa[i];
      in_valid_a = 1'b1;
      chk({tag, "_in_ready"}, 64'(in_ready_a), 64'd1);
      @(negedge clk);
      in_valid_a = 1'b0;
      in_x_a     = {$urandom, $urandom};   // must not affect the layer
      n   = 1;
      nrd = 0;
      while (!out_valid_a && n < 100) begin
         if (w_rd_en_a) begin
            chk({tag, "_w_addr"}, 64'(w_addr_a), 64'(nrd));
            nrd++;
         end
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(M + L + 2));
      chk({tag, "_reads"}, 64'(nrd), 64'(M));
      chk({tag, "_out_y"}, 64'(out_y_a), 64'(exp));
      chk({tag, "_busy"}, 64'(busy_a), 64'd1);
      chk({tag, "_in_ready_done"}, 64'(in_ready_a), 64'd0);
   endtask

   task automatic release_a(input string tag);
      @(negedge clk);
      out_ready_a = 1'b1;
      @(negedge clk);
      out_ready_a = 1'b0;
      chk({tag, "_rel_in_ready"}, 64'(in_ready_a), 64'd1);
      chk({tag, "_rel_out_valid"}, 64'(out_valid_a), 64'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      logic [M*DW-1:0] exp;
      logic [M*DW-1:0] expq [$];
      int              acc_cyc [$];
      int              cyc;
      int              outs;
      bit              chg;
      int              n;
      int              nrd;
      logic [DW-1:0]   exp_b;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready_a), 64'd1);
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_out_valid", 64'(out_valid_a), 64'd0);
      chk("rst_w_rd_en", 64'(w_rd_en_a), 64'd0);
      chk("rst_w_addr", 64'(w_addr_a), 64'd0);
      chk("rst_out_y", 64'(out_y_a), 64'd0);
      chk("rst_p_x", 64'(p_x_a), 64'd0);
      rst_n = 1'b1;

      // single layer: x={1,2,3,4}, row k w={k,0,0,0}, b=k -> y[k]=2k
      for (int i = 0; i < N; i++) xa[i] = elem_t'(i + 1);
      for (int k = 0; k < M; k++) begin
         for (int i = 0; i < N; i++) wmem_a[k][i] = (i == 0) ? elem_t'(k) : '0;
         bmem_a[k] = elem_t'(k);
         exp[k*DW +: DW] = DW'(2 * k);
      end
      run_layer_a("directed", exp);

      // backpressure in done, with an ignored in_valid pulse
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         in_valid_a = (c == 5);
         chk("bp_out_valid", 64'(out_valid_a), 64'd1);
         chk("bp_in_ready", 64'(in_ready_a), 64'd0);
         chk("bp_out_y", 64'(out_y_a), 64'(exp));
      end
      @(negedge clk);
      in_valid_a = 1'b0;
      chk("bp_still_done", 64'(out_valid_a), 64'd1);
      release_a("bp");
      @(negedge clk);
      chk("bp_idle_busy", 64'(busy_a), 64'd0);

      // negative results: w=0, b=-5
      for (int k = 0; k < M; k++) begin
         for (int i = 0; i < N; i++) wmem_a[k][i] = '0;
         bmem_a[k] = -8'sd5;
         exp[k*DW +: DW] = Relu ? 8'h00 : 8'hFB;
      end
      for (int i = 0; i < N; i++) xa[i] = elem_t'($urandom);
      run_layer_a("negative", exp);
      release_a("negative");

      // random layers
      for (int r = 0; r < 4; r++) begin
         rand_mem_a();
         run_layer_a("random", ref_a(xa));
         release_a("random");
      end

      // back-to-back layers with in_valid and out_ready held high
      rand_mem_a();
      @(negedge clk);
      for (int i = 0; i < N; i++) in_x_a[i] = xa[i];
      in_valid_a  = 1'b1;
      out_ready_a = 1'b1;
      cyc  = 0;
      outs = 0;
      chg  = 1'b0;
      while (outs < 3 && cyc < 200) begin
         if (chg) begin
            for (int i = 0; i < N; i++) begin
               xa[i]     = elem_t'($urandom);
               in_x_a[i] = xa[i];
            end
            chg = 1'b0;
         end
         if (in_valid_a && in_ready_a) begin
            if (acc_cyc.size() > 0) chk("b2b_spacing", 64'(cyc - acc_cyc[$]), 64'd12);
            acc_cyc.push_back(cyc);
            expq.push_back(ref_a(xa));
            chg = 1'b1;
         end
         if (out_valid_a) begin
            if (expq.size() == 0) begin
               chk("b2b_spurious_out", 64'(out_valid_a), 64'd0);
            end else begin
               chk("b2b_out_y", 64'(out_y_a), 64'(expq.pop_front()));
            end
            outs++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid_a  = 1'b0;
      out_ready_a = 1'b0;
      chk("b2b_outputs", 64'(outs), 64'd3);
      chk("b2b_accepts", 64'(acc_cyc.size()), 64'd3);

      // reset in the middle of issue
      rand_mem_a();
      @(negedge clk);
      for (int i = 0; i < N; i++) in_x_a[i] = xa[i];
      in_valid_a = 1'b1;
      @(negedge clk);
      in_valid_a = 1'b0;
      @(negedge clk);
      chk("mid_rst_pre_rd_en", 64'(w_rd_en_a), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 64'(in_ready_a), 64'd1);
      chk("mid_rst_busy", 64'(busy_a), 64'd0);
      chk("mid_rst_w_rd_en", 64'(w_rd_en_a), 64'd0);
      chk("mid_rst_w_addr", 64'(w_addr_a), 64'd0);
      chk("mid_rst_out_y", 64'(out_y_a), 64'd0);
      chk("mid_rst_p_x", 64'(p_x_a), 64'd0);
      @(negedge clk);
      chk("mid_rst_out_valid", 64'(out_valid_a), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready_a), 64'd1);
      chk("post_rst_out_valid", 64'(out_valid_a), 64'd0);

      // recovery layer after the abort
      rand_mem_a();
      run_layer_a("recover", ref_a(xa));
      release_a("recover");

      // sweep point: M=1, PERC_LAT=3
      for (int i = 0; i < N; i++) begin
         wmem_b[i] = elem_t'($urandom);
         xb[i]     = elem_t'($urandom);
      end
      bmem_b = elem_t'($urandom);
      exp_b  = neuron(xb, wmem_b, bmem_b);
      @(negedge clk);
      for (int i = 0; i < N; i++) in_x_b[i] = xb[i];
      in_valid_b = 1'b1;
      chk("m1_in_ready", 64'(in_ready_b), 64'd1);
      @(negedge clk);
      in_valid_b = 1'b0;
      n   = 1;
      nrd = 0;
      while (!out_valid_b && n < 100) begin
         if (w_rd_en_b) begin
            chk("m1_w_addr", 64'(w_addr_b), 64'd0);
            nrd++;
         end
         @(negedge clk);
         n++;
      end
      chk("m1_latency", 64'(n), 64'd6);
      chk("m1_reads", 64'(nrd), 64'd1);
      chk("m1_out_y", 64'(out_y_b), 64'(exp_b));
      chk("m1_busy", 64'(busy_b), 64'd1);
      @(negedge clk);
      out_ready_b = 1'b1;
      @(negedge clk);
      out_ready_b = 1'b0;
      chk("m1_rel_out_valid", 64'(out_valid_b), 64'd0);
      chk("m1_rel_in_ready", 64'(in_ready_b), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
